cmp_flags_unit: RTL and testbench
=================================

Name: cmp_flags_unit

Overview:
- Parametrised successor to the single-cycle compare-flag latch. Captures Z/S/C/O from ALU output on `oe`.
- Supports direct flag load from the bus and a LIFO save/restore stack for interrupt entry/exit.
- Evaluates a 4-bit branch condition against the registered flags for the jump unit.
- Sits between the ALU result bus and the control/jump logic.

Parameters:
- W, 8, data width of `cmpin`.
- DEPTH, 4, flag-stack entries (≥1); count width = $clog2(DEPTH+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmpin  input  W  ALU result to flag.
- oe  input  1  capture flags from cmpin/overflow/carry this cycle.
- overflow  input  1  ALU signed overflow.
- carry  input  1  ALU carry out.
- flag_wr  input  1  load flags from flag_din.
- flag_din  input  4  {O,C,S,Z} direct-load value.
- push  input  1  save current flags onto stack.
- pop  input  1  restore flags from stack top.
- err_clr  input  1  clear stk_err.
- cond  input  4  condition select.
- cond_true  output  1  combinational result of cond vs registered flags.
- flags  output  4  registered {O,C,S,Z}.
- stack_full  output  1  count == DEPTH.
- stack_empty  output  1  count == 0.
- stk_err  output  1  sticky stack misuse flag.

Behaviour:
- Reset (reset=0, async):
  - flags=0, count=0, stk_err=0, stack contents don't-care.
  - Outputs: stack_empty=1, stack_full=0.
- Capture on oe=1, visible one cycle later:
  - Z = (cmpin == 0) over all W bits.
  - S = cmpin[W-1], C = carry, O = overflow.
- oe=0 with no other op: flags hold. They are not cleared.
- Flag-source priority, same edge: valid pop > flag_wr > oe.
- push (push=1, pop=0):
  - Not full: stack[count] ← flags as held before this edge; count+1.
  - The flag update from flag_wr/oe still applies on the same edge.
  - Full: push ignored, stk_err ← 1, flag update still applies.
- pop (pop=1, push=0):
  - Not empty: flags ← stack[count-1]; count-1. Overrides flag_wr/oe.
  - Empty: pop ignored, stk_err ← 1, flag_wr/oe apply normally.
- push=1 and pop=1 together:
  - Both ignored, count unchanged, stk_err ← 1.
  - flag_wr/oe apply normally.
- stk_err:
  - Set by any misuse above.
  - Cleared by err_clr=1 when no misuse occurs on the same edge; set wins over clear.
- stack_full and stack_empty decode combinationally from the registered count.
- cond_true decode (combinational, 0 latency from flags):
  - 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 O; 8 !O.
  - 9 !C&!Z; 10 S^O; 11 !(S^O); 12 !Z&!(S^O); 13 Z|(S^O).
  - 14 P (see feature); 15 never.
- Reset asserted mid-sequence: stack is discarded immediately (count=0); there is no partial restore.

Optional Feature:
- Macro: CMP_FLAGS_PARITY_EN.
- Defined:
  - Adds parity flag P = ~^cmpin (1 = even parity), captured on oe only.
  - flag_wr leaves P unchanged.
  - Stack entries become 5 bits {P,O,C,S,Z}; pop restores P.
  - Extra output port pflag (1 bit, registered P, reset 0).
  - cond=14 evaluates P.
- Not defined: no P register, no pflag port, stack entries 4 bits, cond=14 evaluates 0.

Test Plan:
- Reset, then oe=1 with cmpin=0x00, carry=1, overflow=0 → next cycle flags=4'b0101 (C=1, Z=1); cond=1 → cond_true=1; cond=9 → 0.
- oe=1 with cmpin=0x80, overflow=1 → flags=4'b1010; cond=10 (S^O) → 0; cond=11 → 1; cond=15 → 0.
- Push-then-pop restore:
  - Load flags=4'b0011, push; then oe with cmpin=0x01 → flags=0, stack_empty=0.
  - pop with oe=1 and cmpin=0 on the same edge → flags=4'b0011 (pop wins), stack_empty=1.
- Overflow and underflow:
  - DEPTH=4: push 5 times → stack_full=1 after the 4th, stk_err=1 after the 5th, count stays 4.
  - Pop 5 times → 5th pop leaves flags unchanged from the 4th restore, stk_err stays 1.
  - err_clr → stk_err=0.
- push & pop same cycle with flag_wr=1 and flag_din=4'b1000 → count unchanged, stk_err=1, flags=4'b1000.
- With CMP_FLAGS_PARITY_EN: oe with cmpin=0x03 → pflag=1; cmpin=0x07 → pflag=0; cond=14 tracks pflag.
- Without CMP_FLAGS_PARITY_EN: cond=14 → 0.
- Async reset: assert reset mid-clock after 2 pushes → flags=0, stack_empty=1 without waiting for a clk edge.

Source files
------------

// File: rtl/cmp_flags_unit.sv
// rtl/cmp_flags_unit.sv - Z/S/C/O flag register with LIFO save/restore stack and branch-condition decode
// Optional parity flag P enabled by defining CMP_FLAGS_PARITY_EN.
module cmp_flags_unit #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cmpin,
  input  logic         oe,
  input  logic         overflow,
  input  logic         carry,
  input  logic         flag_wr,
  input  logic [3:0]   flag_din,
  input  logic         push,
  input  logic         pop,
  input  logic         err_clr,
  input  logic [3:0]   cond,
  output logic         cond_true,
  output logic [3:0]   flags,
  output logic         stack_full,
  output logic         stack_empty,
`ifdef CMP_FLAGS_PARITY_EN
  output logic         pflag,
`endif
  output logic         stk_err
);

  localparam int CW = $clog2(DEPTH + 1);
`ifdef CMP_FLAGS_PARITY_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [EW-1:0] stack_q [DEPTH];
  logic [EW-1:0] top_entry;
  logic [EW-1:0] cur_entry;
  logic          push_ok, pop_ok, misuse;
  logic          p_cur;

  assign stack_full  = (count_q == FULL_CNT);
  assign stack_empty = (count_q == '0);

  assign push_ok = push & ~pop & ~stack_full;
  assign pop_ok  = pop & ~push & ~stack_empty;
  assign misuse  = (push & pop) | (push & ~pop & stack_full) | (pop & ~push & stack_empty);

`ifdef CMP_FLAGS_PARITY_EN
  logic p_q, p_d;
  assign p_cur     = p_q;
  assign pflag     = p_q;
  assign cur_entry = {p_q, flags_q};

  always_comb begin
    p_d = p_q;
    if (pop_ok)  p_d = top_entry[4];
    else if (oe) p_d = ~^cmpin;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) p_q <= 1'b0;
    else        p_q <= p_d;
  end
`else
  assign p_cur     = 1'b0;
  assign cur_entry = flags_q;
`endif

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) top_entry = stack_q[i];
    end
  end

  // A valid pop overrides both direct load and ALU capture.
  always_comb begin
    flags_d = flags_q;
    if (pop_ok)       flags_d = top_entry[3:0];
    else if (flag_wr) flags_d = flag_din;
    else if (oe)      flags_d = {overflow, carry, cmpin[W-1], (cmpin == '0)};
  end

  always_comb begin
    count_d = count_q;
    if (push_ok)     count_d = count_q + CW'(1);
    else if (pop_ok) count_d = count_q - CW'(1);
  end

  always_comb begin
    err_d = err_q;
    if (misuse)       err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; the count alone defines what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && count_q == CW'(i)) stack_q[i] <= cur_entry;
    end
  end

  assign flags   = flags_q;
  assign stk_err = err_q;

  always_comb begin
    logic z, c, s, o;
    {o, c, s, z} = flags_q;
    cond_true = 1'b0;
    case (cond)
      4'd0:  cond_true = 1'b1;
      4'd1:  cond_true = z;
      4'd2:  cond_true = ~z;
      4'd3:  cond_true = c;
      4'd4:  cond_true = ~c;
      4'd5:  cond_true = s;
      4'd6:  cond_true = ~s;
      4'd7:  cond_true = o;
      4'd8:  cond_true = ~o;
      4'd9:  cond_true = ~c & ~z;
      4'd10: cond_true = s ^ o;
      4'd11: cond_true = ~(s ^ o);
      4'd12: cond_true = ~z & ~(s ^ o);
      4'd13: cond_true = z | (s ^ o);
      4'd14: cond_true = p_cur;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cmp_flags_unit.sv
// tb/tb_cmp_flags_unit.sv - randomized and directed bench for cmp_flags_unit against a queue-based model
// Parity checks compile in when CMP_FLAGS_PARITY_EN is defined.
module tb_cmp_flags_unit;
  localparam int W = 8;
  localparam int DEPTH = 4;

  logic clk = 0;
  logic reset = 0;
  logic [W-1:0] cmpin = 0;
  logic oe = 0, overflow = 0, carry = 0, flag_wr = 0, push = 0, pop = 0, err_clr = 0;
  logic [3:0] flag_din = 0, cond = 0;
  logic cond_true, stack_full, stack_empty, stk_err;
  logic [3:0] flags;
`ifdef CMP_FLAGS_PARITY_EN
  logic pflag;
`endif

  int nchecks = 0;
  int nerrors = 0;

  logic [3:0] m_flags = 0;
  logic       m_p = 0;
  logic       m_err = 0;
  logic [4:0] m_stk[$];

  cmp_flags_unit #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmpin(cmpin), .oe(oe), .overflow(overflow), .carry(carry),
    .flag_wr(flag_wr), .flag_din(flag_din), .push(push), .pop(pop), .err_clr(err_clr),
    .cond(cond), .cond_true(cond_true), .flags(flags), .stack_full(stack_full),
    .stack_empty(stack_empty),
`ifdef CMP_FLAGS_PARITY_EN
    .pflag(pflag),
`endif
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f, input logic p);
    logic z, cy, s, o;
    {o, cy, s, z} = f;
    case (c)
      0: return 1;   1: return z;    2: return !z;   3: return cy;
      4: return !cy; 5: return s;    6: return !s;   7: return o;
      8: return !o;  9: return !cy && !z;            10: return s != o;
      11: return s == o;             12: return !z && (s == o);
      13: return z || (s != o);
`ifdef CMP_FLAGS_PARITY_EN
      14: return p;
`else
      14: return 0;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic idle();
    oe = 0; flag_wr = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then step the DUT.
  task automatic tick();
    logic misuse = 0;
    logic popped = 0;
    logic [4:0] e = 0;
    if (push && pop) misuse = 1;
    else if (push) begin
      if (m_stk.size() == DEPTH) misuse = 1;
      else m_stk.push_back({m_p, m_flags});
    end else if (pop) begin
      if (m_stk.size() == 0) misuse = 1;
      else begin e = m_stk.pop_back(); popped = 1; end
    end
    if (popped) begin
      m_flags = e[3:0];
      m_p = e[4];
    end else begin
      if (flag_wr) m_flags = flag_din;
      else if (oe) m_flags = {overflow, carry, cmpin[W-1], cmpin == 0};
      if (oe) m_p = ~^cmpin;
    end
    if (misuse) m_err = 1;
    else if (err_clr) m_err = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    nchecks++; if (flags !== 4'b0) begin nerrors++; $display("FAIL reset_flags got %b want 0000", flags); end
    nchecks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin nerrors++; $display("FAIL reset_stack got e=%b f=%b want e=1 f=0", stack_empty, stack_full); end
    nchecks++; if (stk_err !== 1'b0) begin nerrors++; $display("FAIL reset_err got %b want 0", stk_err); end
    @(negedge clk);
    reset = 1;
    m_flags = 0; m_p = 0; m_err = 0; m_stk.delete();
  endtask

  task automatic test_capture();
    idle(); oe = 1; cmpin = 8'h00; carry = 1; overflow = 0;
    tick(); idle();
    nchecks++; if (flags !== 4'b0101) begin nerrors++; $display("FAIL cap_zero got %b want 0101", flags); end
    cond = 1; #1;
    nchecks++; if (cond_true !== 1'b1) begin nerrors++; $display("FAIL cond1 got %b want 1", cond_true); end
    cond = 9; #1;
    nchecks++; if (cond_true !== 1'b0) begin nerrors++; $display("FAIL cond9 got %b want 0", cond_true); end
    oe = 1; cmpin = 8'h80; carry = 0; overflow = 1;
    tick(); idle();
    nchecks++; if (flags !== 4'b1010) begin nerrors++; $display("FAIL cap_neg got %b want 1010", flags); end
    cond = 10; #1;
    nchecks++; if (cond_true !== 1'b0) begin nerrors++; $display("FAIL cond10 got %b want 0", cond_true); end
    cond = 11; #1;
    nchecks++; if (cond_true !== 1'b1) begin nerrors++; $display("FAIL cond11 got %b want 1", cond_true); end
    cond = 15; #1;
    nchecks++; if (cond_true !== 1'b0) begin nerrors++; $display("FAIL cond15 got %b want 0", cond_true); end
    cmpin = 8'h00;
    tick(); tick();
    nchecks++; if (flags !== 4'b1010) begin nerrors++; $display("FAIL hold got %b want 1010", flags); end
  endtask

  task automatic test_push_pop();
    idle(); flag_wr = 1; flag_din = 4'b0011;
    tick(); idle(); push = 1;
    tick(); idle(); oe = 1; cmpin = 8'h01; carry = 0; overflow = 0;
    tick(); idle();
    nchecks++; if (flags !== 4'b0000 || stack_empty !== 1'b0) begin nerrors++; $display("FAIL push_then_oe got f=%b e=%b want f=0000 e=0", flags, stack_empty); end
    pop = 1; oe = 1; cmpin = 8'h00;
    tick(); idle();
    nchecks++; if (flags !== 4'b0011 || stack_empty !== 1'b1) begin nerrors++; $display("FAIL pop_wins got f=%b e=%b want f=0011 e=1", flags, stack_empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      idle(); push = 1; flag_wr = 1; flag_din = 4'(i + 4);
      tick(); idle();
      if (i == 3) begin
        nchecks++; if (stack_full !== 1'b1 || stk_err !== 1'b0) begin nerrors++; $display("FAIL full_at4 got f=%b err=%b want f=1 err=0", stack_full, stk_err); end
      end
      if (i == 4) begin
        nchecks++; if (stack_full !== 1'b1 || stk_err !== 1'b1) begin nerrors++; $display("FAIL push_over got f=%b err=%b want f=1 err=1", stack_full, stk_err); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      idle(); pop = 1;
      tick(); idle();
      nchecks++; if (flags !== m_flags) begin nerrors++; $display("FAIL pop%0d got %b want %b", i, flags, m_flags); end
    end
    nchecks++; if (flags !== 4'b0011 || stk_err !== 1'b1 || stack_empty !== 1'b1) begin nerrors++; $display("FAIL underflow got f=%b err=%b e=%b want f=0011 err=1 e=1", flags, stk_err, stack_empty); end
    err_clr = 1;
    tick(); idle();
    nchecks++; if (stk_err !== 1'b0) begin nerrors++; $display("FAIL err_clr got %b want 0", stk_err); end
  endtask

  task automatic test_back_to_back();
    idle(); push = 1;
    tick(); idle();
    push = 1; pop = 1; flag_wr = 1; flag_din = 4'b1000; err_clr = 1;
    tick(); idle();
    nchecks++; if (flags !== 4'b1000 || stk_err !== 1'b1) begin nerrors++; $display("FAIL push_pop_same got f=%b err=%b want f=1000 err=1", flags, stk_err); end
    nchecks++; if (stack_empty !== 1'b0 || stack_full !== 1'b0) begin nerrors++; $display("FAIL push_pop_cnt got e=%b f=%b want e=0 f=0", stack_empty, stack_full); end
    pop = 1;
    tick(); idle();
    nchecks++; if (flags !== 4'b0011 || stack_empty !== 1'b1) begin nerrors++; $display("FAIL pop_after_same got f=%b e=%b want f=0011 e=1", flags, stack_empty); end
    err_clr = 1;
    tick(); idle();
  endtask

  task automatic test_parity();
    cond = 14;
    oe = 1; cmpin = 8'h03;
    tick(); idle();
`ifdef CMP_FLAGS_PARITY_EN
    nchecks++; if (pflag !== 1'b1 || cond_true !== 1'b1) begin nerrors++; $display("FAIL par_03 got p=%b c=%b want 1 1", pflag, cond_true); end
`else
    nchecks++; if (cond_true !== 1'b0) begin nerrors++; $display("FAIL cond14_03 got %b want 0", cond_true); end
`endif
    oe = 1; cmpin = 8'h07;
    tick(); idle();
`ifdef CMP_FLAGS_PARITY_EN
    nchecks++; if (pflag !== 1'b0 || cond_true !== 1'b0) begin nerrors++; $display("FAIL par_07 got p=%b c=%b want 0 0", pflag, cond_true); end
    flag_wr = 1; flag_din = 4'b1111;
    tick(); idle();
    nchecks++; if (pflag !== 1'b0) begin nerrors++; $display("FAIL par_flagwr got %b want 0", pflag); end
`else
    nchecks++; if (cond_true !== 1'b0) begin nerrors++; $display("FAIL cond14_07 got %b want 0", cond_true); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      push = (r < 4) || (r == 9);
      pop = ((r >= 4) && (r < 8)) || (r == 9);
      err_clr = ($urandom_range(0, 7) == 0);
      oe = $urandom_range(0, 1);
      flag_wr = ($urandom_range(0, 3) == 0);
      flag_din = 4'($urandom);
      cmpin = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      carry = $urandom_range(0, 1);
      overflow = $urandom_range(0, 1);
      cond = 4'($urandom);
      tick();
      nchecks++; if (flags !== m_flags) begin nerrors++; $display("FAIL rnd_flags n=%0d got %b want %b", n, flags, m_flags); end
      nchecks++; if (stack_empty !== (m_stk.size() == 0) || stack_full !== (m_stk.size() == DEPTH)) begin
        nerrors++; $display("FAIL rnd_stack n=%0d got e=%b f=%b want depth %0d", n, stack_empty, stack_full, m_stk.size()); end
      nchecks++; if (stk_err !== m_err) begin nerrors++; $display("FAIL rnd_err n=%0d got %b want %b", n, stk_err, m_err); end
      nchecks++; if (cond_true !== cond_ref(cond, m_flags, m_p)) begin nerrors++; $display("FAIL rnd_cond n=%0d cond=%0d got %b want %b", n, cond, cond_true, cond_ref(cond, m_flags, m_p)); end
`ifdef CMP_FLAGS_PARITY_EN
      nchecks++; if (pflag !== m_p) begin nerrors++; $display("FAIL rnd_pflag n=%0d got %b want %b", n, pflag, m_p); end
`endif
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle(); err_clr = 1; flag_wr = 1; flag_din = 4'b0110;
    tick(); idle();
    push = 1; tick(); tick(); idle();
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    nchecks++; if (flags !== 4'b0000 || stack_empty !== 1'b1) begin nerrors++; $display("FAIL async_reset got f=%b e=%b want f=0000 e=1", flags, stack_empty); end
    nchecks++; if (stk_err !== 1'b0) begin nerrors++; $display("FAIL async_reset_err got %b want 0", stk_err); end
    @(negedge clk);
    reset = 1;
    m_flags = 0; m_p = 0; m_err = 0; m_stk.delete();
    pop = 1;
    tick(); idle();
    nchecks++; if (stk_err !== 1'b1 || flags !== 4'b0000) begin nerrors++; $display("FAIL post_reset_pop got err=%b f=%b want err=1 f=0000", stk_err, flags); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_push_pop();
    test_overflow();
    test_back_to_back();
    test_parity();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
